// File: rtl/asrm_gpio_pkg.sv
// Shared constants, register-select type and offset decoder for the ASRM GPIO block.
// Optional input synchronizer is selected by the ASRM_GPIO_SYNC_EN macro (see asrm_gpio_ctrl).
package asrm_gpio_pkg;

  localparam int GPIO_OFF_GPI  = 32'sd0;
  localparam int GPIO_OFF_GPO  = 32'sd1;
  localparam int GPIO_OFF_SET  = 32'sd2;
  localparam int GPIO_OFF_CLR  = 32'sd3;
  localparam int GPIO_OFF_TGL  = 32'sd4;
  localparam int GPIO_NUM_REGS = 32'sd5;

  typedef enum logic [2:0] {
    REG_GPI  = 3'd0,
    REG_GPO  = 3'd1,
    REG_SET  = 3'd2,
    REG_CLR  = 3'd3,
    REG_TGL  = 3'd4,
    REG_NONE = 3'd7
  } gpio_reg_e;

  // Offsets past the register file map to REG_NONE so they read 0 and ignore writes.
  function automatic gpio_reg_e gpio_decode(input logic [31:0] offset);
    gpio_reg_e sel;
    sel = REG_NONE;
    if (offset < 32'(GPIO_NUM_REGS)) begin
      case (offset)
        32'(GPIO_OFF_GPI): sel = REG_GPI;
        32'(GPIO_OFF_GPO): sel = REG_GPO;
        32'(GPIO_OFF_SET): sel = REG_SET;
        32'(GPIO_OFF_CLR): sel = REG_CLR;
        32'(GPIO_OFF_TGL): sel = REG_TGL;
        default:           sel = REG_NONE;
      endcase
    end else begin
      sel = REG_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/asrm_gpio_sync.sv
// Two-flop synchronizer for the asynchronous GPI pins, synchronous active-high reset.
module asrm_gpio_sync #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta_r;
  logic [width-1:0] sync_r;

  // Capture stage followed by the stable stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/asrm_gpio_ctrl.sv
// ASRM GPIO peripheral: GPI/GPO/SET/CLR/TGL register window at base_addr.
// Define ASRM_GPIO_SYNC_EN to put GPI behind a two-flop synchronizer.
module asrm_gpio_ctrl
  import asrm_gpio_pkg::*;
#(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 4,
  parameter int base_addr      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [wordsize-1:0]       gpi,
  output logic [wordsize-1:0]       gpo
);

  localparam logic [base_addr_size-1:0] BASE_ADDR_L = base_addr[base_addr_size-1:0];

  logic [base_addr_size-1:0] offset_s;
  logic                      in_range_s;
  gpio_reg_e                 sel_s;
  logic                      wr_s;
  logic [wordsize-1:0]       gpi_s;
  logic [wordsize-1:0]       gpo_nxt_s;
  logic [wordsize-1:0]       gpo_r;

  function automatic logic [wordsize-1:0] apply_write(
    input gpio_reg_e           sel,
    input logic [wordsize-1:0] cur,
    input logic [wordsize-1:0] wdata
  );
    logic [wordsize-1:0] res;
    case (sel)
      REG_GPO: res = wdata;
      REG_SET: res = cur | wdata;
      REG_CLR: res = cur & ~wdata;
      REG_TGL: res = cur ^ wdata;
      default: res = cur;
    endcase
    return res;
  endfunction

`ifdef ASRM_GPIO_SYNC_EN
  asrm_gpio_sync #(
    .width (wordsize)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (gpi),
    .q     (gpi_s)
  );
`else
  assign gpi_s = gpi;
`endif

  assign offset_s   = addr - BASE_ADDR_L;
  assign in_range_s = (addr >= BASE_ADDR_L);

  // Address decode; the subtraction wraps, so the lower bound is checked separately.
  always_comb begin
    sel_s = REG_NONE;
    if (in_range_s) begin
      sel_s = gpio_decode(32'(offset_s));
    end else begin
      sel_s = REG_NONE;
    end
  end

  assign wr_s      = enable & write_en & (sel_s != REG_NONE);
  assign gpo_nxt_s = apply_write(sel_s, gpo_r, data_in);

  // Output register; reset takes priority over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpo_r <= '0;
    end else if (wr_s) begin
      gpo_r <= gpo_nxt_s;
    end else begin
      gpo_r <= gpo_r;
    end
  end

  // Zero-latency read mux; deselected or unmapped accesses return 0.
  always_comb begin
    data_out = '0;
    if (enable) begin
      case (sel_s)
        REG_GPI:                            data_out = gpi_s;
        REG_GPO, REG_SET, REG_CLR, REG_TGL: data_out = gpo_r;
        default:                            data_out = '0;
      endcase
    end else begin
      data_out = '0;
    end
  end

  assign gpo = gpo_r;

endmodule

// File: tb/tb_asrm_gpio_ctrl.sv
// Self-checking bench for asrm_gpio_ctrl: directed plan followed by random bus traffic.
module tb_asrm_gpio_ctrl;

  localparam int W    = 16;
  localparam int AW   = 4;
  localparam int BASE = 2;
`ifdef ASRM_GPIO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] addr;
  logic          write_en;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic [W-1:0]  gpi;
  logic [W-1:0]  gpo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] gpo_m;
  logic [W-1:0] hist[$];
  int           since_rst;
  logic [W-1:0] rd;

  always #5 clk = ~clk;

  asrm_gpio_ctrl #(
    .wordsize       (W),
    .base_addr_size (AW),
    .base_addr      (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .gpi      (gpi),
    .gpo      (gpo)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Value visible at offset 0: live pins, or the pin value LAT edges ago (0 if reset is too recent).
  function automatic logic [W-1:0] gpi_view();
    if (LAT == 0) return gpi;
    if (since_rst < LAT) return '0;
    return hist[LAT-1];
  endfunction

  function automatic logic [W-1:0] model_read(input int a, input logic en);
    if (!en || a < BASE || (a - BASE) > 4) return '0;
    if (a == BASE) return gpi_view();
    return gpo_m;
  endfunction

  task automatic tick();
    int off;
    @(posedge clk);
    off = int'(addr) - BASE;
    if (reset) begin
      gpo_m     = '0;
      since_rst = 0;
      hist.delete();
    end else begin
      if (enable && write_en && off >= 0 && off <= 4) begin
        case (off)
          1: gpo_m = data_in;
          2: gpo_m = gpo_m | data_in;
          3: gpo_m = gpo_m & ~data_in;
          4: gpo_m = gpo_m ^ data_in;
          default: gpo_m = gpo_m;
        endcase
      end
      hist.push_front(gpi);
      if (hist.size() > 4) void'(hist.pop_back());
      since_rst++;
    end
    #1;
  endtask

  // One bus cycle: check the combinational read, clock it, check the pins.
  task automatic op(input int a, input logic we, input logic en, input logic [W-1:0] d,
                    input logic rs, input string tag, output logic [W-1:0] rdv);
    addr     = AW'(a);
    write_en = we;
    enable   = en;
    data_in  = d;
    reset    = rs;
    #1;
    rdv = data_out;
    chk({tag, "_rd"}, data_out, model_read(a, en));
    tick();
    chk({tag, "_gpo"}, gpo, gpo_m);
    write_en = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    gpo_m = '0; since_rst = 0;
    reset = 1'b1; enable = 1'b1; write_en = 1'b0; addr = '0; data_in = '0; gpi = 16'hABCD;
    tick();
    reset = 1'b0;
    chk("rst_gpo", gpo, 16'h0000);
    op(3, 1'b0, 1'b1, 16'h0000, 1'b0, "rst_read", rd);
    chk("rst_read_c", rd, 16'h0000);

    op(3, 1'b1, 1'b1, 16'h0007, 1'b0, "wr_gpo", rd);
    chk("wr_gpo_c", gpo, 16'h0007);
    op(3, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_gpo", rd);
    chk("rd_gpo_c", rd, 16'h0007);

    op(2, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_gpi", rd);
    chk("rd_gpi_c", rd, 16'hABCD);
    op(2, 1'b1, 1'b1, 16'h1234, 1'b0, "wr_gpi", rd);
    chk("wr_gpi_c", gpo, 16'h0007);

    op(4, 1'b1, 1'b1, 16'h00F0, 1'b0, "set", rd);
    chk("set_c", gpo, 16'h00F7);
    op(5, 1'b1, 1'b1, 16'h0003, 1'b0, "clr", rd);
    chk("clr_c", gpo, 16'h00F4);
    op(6, 1'b1, 1'b1, 16'hFFFF, 1'b0, "tgl", rd);
    chk("tgl_c", gpo, 16'hFF0B);

    op(0, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_a0", rd);
    chk("rd_a0_c", rd, 16'h0000);
    op(1, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_a1", rd);
    chk("rd_a1_c", rd, 16'h0000);
    op(7, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_a7", rd);
    chk("rd_a7_c", rd, 16'h0000);
    op(0, 1'b1, 1'b1, 16'h5555, 1'b0, "wr_a0", rd);
    chk("wr_a0_c", gpo, 16'hFF0B);

    op(3, 1'b1, 1'b0, 16'hFFFF, 1'b0, "dis_wr", rd);
    chk("dis_wr_rd_c", rd, 16'h0000);
    chk("dis_wr_c", gpo, 16'hFF0B);

    op(3, 1'b1, 1'b1, 16'hFFFF, 1'b1, "rst_wr", rd);
    chk("rst_wr_c", gpo, 16'h0000);

    // GPI change latency through offset 0
    gpi = 16'h1357;
    op(2, 1'b0, 1'b1, 16'h0000, 1'b0, "gpi_lat0", rd);
    op(2, 1'b0, 1'b1, 16'h0000, 1'b0, "gpi_lat1", rd);
    op(2, 1'b0, 1'b1, 16'h0000, 1'b0, "gpi_lat2", rd);
    chk("gpi_lat_c", rd, 16'h1357);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) gpi = W'($urandom);
      op(int'($urandom_range(15)), 1'($urandom), ($urandom_range(9) != 0),
         W'($urandom), ($urandom_range(31) == 0), "rand", rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asrm_gpio_ctrl.md
# asrm_gpio_ctrl

General-purpose I/O peripheral for the ASRM system bus. The RTL module is named `asrm_gpio_ctrl`; it is the reworked `asrm_gpio` block. It exposes a word-wide input port (GPI) and a word-wide output port (GPO) through a small memory-mapped register window placed at a configurable base address. It sits beside the other bus peripherals and is decoded by address comparison inside the block.

## Interface
- `wordsize`, default 16: width of the data bus, GPI and GPO.
- `base_addr_size`, default 4: width of `addr`.
- `base_addr`, default 2: address of register offset 0.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; one clock domain (`clk`).
- `enable` in 1: block select; when low, writes are ignored and `data_out` is 0.
- `addr` in `base_addr_size`: bus address.
- `write_en` in 1: write strobe.
- `data_in` in `wordsize`: write data.
- `data_out` out `wordsize`: read data.
- `gpi` in `wordsize`: external inputs, asynchronous to `clk`.
- `gpo` out `wordsize`: external outputs, driven directly from the GPO register.

## Operation
- `offset = addr - base_addr`, computed modulo 2^`base_addr_size`. The window is hit when `addr >= base_addr` and `offset <= 4`.
- Offsets that fall above the maximum of `addr` are unreachable; this is not an error.
- Register map:
  - offset 0 GPI: read-only. Returns the sampled GPI value; writes are ignored.
  - offset 1 GPO: read/write. A write loads `data_in`.
  - offset 2 SET: a write does `gpo |= data_in`.
  - offset 3 CLR: a write does `gpo &= ~data_in`.
  - offset 4 TGL: a write does `gpo ^= data_in`.
  - Reads of offsets 1 to 4 return the current `gpo`.
- A write takes effect only when `enable & write_en` and the address is in the window.
- Addresses outside the window read 0 and writes to them have no effect.
- Only one register is written per cycle, so no simultaneous-write conflicts arise.

## Timing
- Reset (sampled on a rising edge with `reset`=1):
  - `gpo` = 0.
  - Synchronizer flops = 0.
  - `data_out` then reads 0 for GPO, and 0 for GPI until new samples propagate.
- A write is committed on the rising edge where the write conditions hold. The new `gpo` value is visible on the pin, and on read-back, in the following cycle.
- Reads are combinational from `addr`/`enable` and register state: zero-cycle read latency with no handshake.
- Reset asserted together with a write: reset wins, and `gpo` becomes 0.
- A GPI change reaches offset 0 after 2 rising edges with the synchronizer compiled in, and after 0 edges without it.

## Configuration
- Macro: `ASRM_GPIO_SYNC_EN`.
- Defined: `gpi` passes through a two-flop synchronizer, reset to 0, before being read at offset 0.
- Undefined: offset 0 returns `gpi` combinationally, with no flops.

## Structure
- Package `asrm_gpio_pkg` holds:
  - Offset constants `GPIO_OFF_GPI`=0, `GPIO_OFF_GPO`=1, `GPIO_OFF_SET`=2, `GPIO_OFF_CLR`=3, `GPIO_OFF_TGL`=4.
  - `GPIO_NUM_REGS`=5.
- Sub-module `asrm_gpio_sync`: a parameterized-width two-flop synchronizer with synchronous reset. It is instantiated only under `ASRM_GPIO_SYNC_EN`.

## Test plan
All scenarios use `wordsize`=16, `base_addr_size`=4, `base_addr`=2, `enable`=1, `gpi`=0xABCD.
- Assert reset for 1 cycle -> `gpo`=0x0000, and a read at addr 3 returns 0x0000.
- Write 0x0007 at addr 3 -> `gpo`=0x0007 the next cycle, and a read at addr 3 returns 0x0007.
- Read addr 2 -> 0xABCD; with `ASRM_GPIO_SYNC_EN` this appears 2 edges after `gpi` settles from reset. A write of 0x1234 to addr 2 leaves `gpo` unchanged.
- From `gpo`=0x0007:
  - SET 0x00F0 at addr 4 gives 0x00F7.
  - CLR 0x0003 at addr 5 gives 0x00F4.
  - TGL 0xFFFF at addr 6 gives 0xFF0B.
- Read addr 0, 1 and 7 -> 0. Write 0x5555 at addr 0 -> `gpo` unchanged.
- Drop `enable` to 0 and write 0xFFFF at addr 3 -> `gpo` unchanged and `data_out`=0. Reset asserted during a write -> `gpo`=0.
